ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
Upstream stage of the keyboard display top: receives raw PS/2 device-to-host frames and tracks key state, feeding scan codes to the ASCII mapper and seven-segment encoders. It synchronises ps2_clk/ps2_data, deframes 11-bit frames with start, parity and stop checks, and decodes E0/F0 prefixes. It exposes the held key's make code, a press pulse, and a wrapping press counter for the counter display.

Parameters:
TIMEOUT_CYC, 50000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned
CNT_W, 16, width of press_cnt

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk
ps2_data  input  1  raw PS/2 data, asynchronous to clk
code  output  8  make code of currently held key; 0x00 when none held
extended  output  1  held key was E0-prefixed
key_down  output  1  a key is currently held
ready  output  1  one-cycle pulse per new key press (not typematic repeats)
press_cnt  output  CNT_W  count of accepted presses, wraps to 0
frame_err  output  1  one-cycle pulse on rejected or timed-out frame

Behaviour:
- Reset: asynchronous while resetn=0. Clears code=0, extended=0, key_down=0, ready=0, press_cnt=0, frame_err=0, bit counter, shift register, timeout counter, synchronisers (to 1), prefix FSM=IDLE. A reset mid-frame discards the partial frame.
- Sync: ps2_clk and ps2_data each pass through 2 flops. A third ps2_clk flop provides edge detect. A falling edge is detected when the delayed value is 1 and the current synced value is 0. Synced data is sampled in that same cycle.
- Deframe: bit counter runs 0..10, data LSB first.
  - Bit 0 sampled as 1 is a spurious start: ignored, counter stays 0, no error.
  - On bit 10, the frame is good if the stop bit is 1 and the data plus parity bits hold an odd number of ones.
  - Good frame: byte event handled by the FSM. Outputs update on the rising clk edge following the detection cycle (1-cycle latency).
  - Bad frame: frame_err pulses 1 cycle; byte dropped; FSM state unchanged; counter returns to 0.
- Timeout: while counter≠0, count cycles since the last falling edge. On reaching TIMEOUT_CYC: counter←0, frame_err pulses 1 cycle, FSM unchanged.
- Prefix FSM states: IDLE, AFT_E0, AFT_F0, AFT_E0F0.
  - IDLE: E0→AFT_E0; F0→AFT_F0; other b→make(b,0).
  - AFT_E0: F0→AFT_E0F0; other b→make(b,1), →IDLE.
  - AFT_F0: b→break(b,0), →IDLE.
  - AFT_E0F0: b→break(b,1), →IDLE.
- make(b,e):
  - If key_down and code==b and extended==e: typematic repeat; no change, no pulse.
  - Else: code←b, extended←e, key_down←1, ready pulse, press_cnt←press_cnt+1 mod 2^CNT_W. A new key pressed while another is held replaces it.
- break(b,e):
  - If key_down and code==b and extended==e: key_down←0, code←0, extended←0.
  - Else: ignored (release of a non-displayed key).
- ready and frame_err never assert in the same cycle. Both are 0 in every cycle without an event.

Test Plan:
- Frame 0x16 (bits 0,0,1,1,0,1,0,0,0,0,1: start, data LSB first, parity 0, stop) → one cycle after the 11th edge: code=0x16, key_down=1, extended=0, ready pulse, press_cnt=1.
- Then 0x16 three more times (repeat) → no ready pulse, press_cnt stays 1. Then F0,16 → key_down=0, code=0x00.
- E0,75 → code=0x75, extended=1, press_cnt=2. Then F0,75 (non-extended) → ignored, key_down stays 1. Then E0,F0,75 → key_down=0, extended=0.
- Frame 0x1E with parity bit 0 (wrong) → frame_err 1-cycle pulse, code/press_cnt unchanged. Frame 0x1E with stop bit 0 → frame_err.
- 5 bits sent, then ps2_clk idle high → frame_err exactly TIMEOUT_CYC cycles after the last edge. A following good 0x1E frame decodes to code=0x1E.
- resetn pulsed low after 6 bits of a frame → all outputs 0 immediately. Next full 0x16 frame decodes correctly with press_cnt=1. Separately, press_cnt preloaded near 0xFFFF by 2^16 presses wraps to 0x0000.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver: synchronises the raw bus, deframes 11-bit frames,
// resolves E0/F0 prefixes and tracks the single held key plus a press counter.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       code,
  output logic             extended,
  output logic             key_down,
  output logic             ready,
  output logic [CNT_W-1:0] press_cnt,
  output logic             frame_err,
  output logic [1:0]       prefix_state
);

  typedef enum logic [1:0] {IDLE, AFT_E0, AFT_F0, AFT_E0F0} prefix_t;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic            clk_s1, clk_s2, clk_d;
  logic            data_s1, data_s2;
  logic            fall;
  logic            bit_in;

  logic [3:0]      bit_cnt;
  logic [8:0]      shift_q;
  logic [TO_W-1:0] to_cnt;

  logic            byte_valid, byte_bad, timeout;
  logic [7:0]      byte_val;

  prefix_t         state_q, state_d;
  logic            do_make, do_break, ev_ext, held_match;

  // Two-flop synchronisers; the third clock flop only serves edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_d   <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall     = clk_d & ~clk_s2;
  assign bit_in   = data_s2;
  assign byte_val = shift_q[7:0];

  always_comb begin
    byte_valid = 1'b0;
    byte_bad   = 1'b0;
    timeout    = 1'b0;
    if (fall && bit_cnt == 4'd10) begin
      // shift_q holds data plus parity; the set must have odd weight.
      if (bit_in && ^shift_q) byte_valid = 1'b1;
      else                    byte_bad   = 1'b1;
    end else if (!fall && bit_cnt != 4'd0 && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= 4'd0;
      shift_q <= 9'd0;
      to_cnt  <= '0;
    end else if (fall) begin
      to_cnt <= '0;
      if (bit_cnt == 4'd0) begin
        if (!bit_in) bit_cnt <= 4'd1;
      end else if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        shift_q <= {bit_in, shift_q[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (timeout) begin
        bit_cnt <= 4'd0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    ev_ext   = 1'b0;
    if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (byte_val == 8'hE0)      state_d = AFT_E0;
          else if (byte_val == 8'hF0) state_d = AFT_F0;
          else                        do_make = 1'b1;
        end
        AFT_E0: begin
          if (byte_val == 8'hF0) begin
            state_d = AFT_E0F0;
          end else begin
            do_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        AFT_F0: begin
          do_break = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          do_break = 1'b1;
          ev_ext   = 1'b1;
          state_d  = IDLE;
        end
      endcase
    end
  end

  assign held_match   = key_down && (code == byte_val) && (extended == ev_ext);
  assign prefix_state = state_q;

  // ready and frame_err are single-cycle strobes with no backpressure;
  // the consumer must capture them in the cycle they are high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code      <= 8'h00;
      extended  <= 1'b0;
      key_down  <= 1'b0;
      ready     <= 1'b0;
      press_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      ready     <= do_make && !held_match;
      frame_err <= byte_bad | timeout;
      if (do_make && !held_match) begin
        code      <= byte_val;
        extended  <= ev_ext;
        key_down  <= 1'b1;
        press_cnt <= press_cnt + CNT_W'(1);
      end else if (do_break && held_match) begin
        code     <= 8'h00;
        extended <= 1'b0;
        key_down <= 1'b0;
      end
    end
  end

endmodule
